// File: rtl/dbus_rr_arbiter_if.sv
// dbus_rr_arbiter_if: bundle of the per-master request side and the shared
// slave side of the DBus.
// The slave modport is the arbiter's view of the bus.
// The master modport is the view of the surrounding masters and slaves.
interface dbus_rr_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int BE_W  = DATA_W / 8;

    logic [NUM_MASTERS-1:0]        i_M_Req;
    logic [NUM_MASTERS-1:0]        i_M_Lock;
    logic [NUM_MASTERS-1:0]        o_M_Gnt;
    logic [NUM_MASTERS*ADDR_W-1:0] i_M_Address;
    logic [NUM_MASTERS*BE_W-1:0]   i_M_ByteEn;
    logic [NUM_MASTERS-1:0]        i_M_Read;
    logic [NUM_MASTERS-1:0]        i_M_Write;
    logic [NUM_MASTERS*DATA_W-1:0] i_M_WriteData;
    logic [NUM_MASTERS*DATA_W-1:0] o_M_ReadData;
    logic [NUM_MASTERS-1:0]        o_M_WaitRequest;
    logic [ADDR_W-1:0]             o_S_Address;
    logic [BE_W-1:0]               o_S_ByteEn;
    logic                          o_S_Read;
    logic                          o_S_Write;
    logic [DATA_W-1:0]             o_S_WriteData;
    logic [DATA_W-1:0]             i_S_ReadData;
    logic                          i_S_WaitRequest;
    logic [IDX_W-1:0]              o_LastGntIdx;

    modport slave (
        input  i_M_Req, i_M_Lock, i_M_Address, i_M_ByteEn, i_M_Read, i_M_Write,
        input  i_M_WriteData, i_S_ReadData, i_S_WaitRequest,
        output o_M_Gnt, o_M_ReadData, o_M_WaitRequest, o_S_Address, o_S_ByteEn,
        output o_S_Read, o_S_Write, o_S_WriteData, o_LastGntIdx
    );

    modport master (
        output i_M_Req, i_M_Lock, i_M_Address, i_M_ByteEn, i_M_Read, i_M_Write,
        output i_M_WriteData, i_S_ReadData, i_S_WaitRequest,
        input  o_M_Gnt, o_M_ReadData, o_M_WaitRequest, o_S_Address, o_S_ByteEn,
        input  o_S_Read, o_S_Write, o_S_WriteData, o_LastGntIdx
    );
endinterface

// File: rtl/dbus_rr_arbiter.sv
// dbus_rr_arbiter: N-master round-robin arbiter and AND-OR mux for the shared
// Avalon-style DBus.
// The grant is one-hot and is held while the slave stalls.
// Priority rotates from the index after the last winner.
// Optional macro DBUS_ARB_LOCK_EN: a granted master holding Lock (with Req)
// keeps the bus across transfers, for atomic read-modify-write sequences.
module dbus_rr_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32
) (
    input  logic                i_Clk,
    input  logic                i_nRst,
    dbus_rr_arbiter_if.slave    bus
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int BE_W  = DATA_W / 8;

    logic [NUM_MASTERS-1:0] r_Gnt;
    logic [NUM_MASTERS-1:0] w_GntNxt;
    logic [IDX_W-1:0]       r_Ptr;
    logic [IDX_W-1:0]       w_PtrNxt;
    logic [IDX_W-1:0]       w_WinIdx;
    logic                   w_LockHold;

`ifdef DBUS_ARB_LOCK_EN
    assign w_LockHold = |(r_Gnt & bus.i_M_Lock & bus.i_M_Req);
`else
    assign w_LockHold = 1'b0;
`endif

    // Pick the first requester after r_Ptr; scanning backwards lets the nearest one win last.
    always_comb begin
        w_WinIdx = r_Ptr;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            int               sum;
            logic [IDX_W-1:0] cand;
            sum = int'(r_Ptr) + k;
            if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
            cand = IDX_W'(sum);
            if (bus.i_M_Req[cand]) w_WinIdx = cand;
        end
    end

    // Next grant: hold on stall or lock, idle with no requests, otherwise rotate.
    always_comb begin
        w_GntNxt = r_Gnt;
        w_PtrNxt = r_Ptr;
        if (!bus.i_S_WaitRequest && !w_LockHold) begin
            if (bus.i_M_Req == '0) begin
                w_GntNxt = '0;
            end else begin
                w_GntNxt = NUM_MASTERS'(1) << w_WinIdx;
                w_PtrNxt = w_WinIdx;
            end
        end
    end

    // Grant and last-winner registers; reset leaves master 0 as first in line.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_Gnt <= '0;
            r_Ptr <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            r_Gnt <= w_GntNxt;
            r_Ptr <= w_PtrNxt;
        end
    end

    // Forward the winner onto the shared bus; a zero grant yields an all-zero idle bus.
    always_comb begin
        bus.o_S_Address   = '0;
        bus.o_S_ByteEn    = '0;
        bus.o_S_Read      = 1'b0;
        bus.o_S_Write     = 1'b0;
        bus.o_S_WriteData = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            bus.o_S_Address   = bus.o_S_Address   | (bus.i_M_Address[i*ADDR_W +: ADDR_W]   & {ADDR_W{r_Gnt[i]}});
            bus.o_S_ByteEn    = bus.o_S_ByteEn    | (bus.i_M_ByteEn[i*BE_W +: BE_W]        & {BE_W{r_Gnt[i]}});
            bus.o_S_WriteData = bus.o_S_WriteData | (bus.i_M_WriteData[i*DATA_W +: DATA_W] & {DATA_W{r_Gnt[i]}});
            bus.o_S_Read      = bus.o_S_Read  | (bus.i_M_Read[i]  & r_Gnt[i]);
            bus.o_S_Write     = bus.o_S_Write | (bus.i_M_Write[i] & r_Gnt[i]);
        end
    end

    // Return read data only to the granted master; the others see zero.
    always_comb begin
        bus.o_M_ReadData = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            bus.o_M_ReadData[i*DATA_W +: DATA_W] = bus.i_S_ReadData & {DATA_W{r_Gnt[i]}};
        end
    end

    assign bus.o_M_WaitRequest = r_Gnt & {NUM_MASTERS{bus.i_S_WaitRequest}};
    assign bus.o_M_Gnt         = r_Gnt;
    assign bus.o_LastGntIdx    = r_Ptr;

`ifndef SYNTHESIS
    // The grant register must never have more than one bit set.
    always_ff @(posedge i_Clk) begin
        if (i_nRst) begin
            assert ($onehot0(r_Gnt));
        end
    end
`endif
endmodule

// File: tb/tb_dbus_rr_arbiter.sv
// tb_dbus_rr_arbiter: directed scenarios with literal expectations, then a
// randomized run checked every cycle against a behavioural round-robin model.
module tb_dbus_rr_arbiter;
    localparam int N  = 3;
    localparam int A  = 30;
    localparam int D  = 32;
    localparam int BE = D / 8;

    logic w_SysClk = 1'b0;
    logic r_nRst   = 1'b0;
    logic cmpEn    = 1'b0;
    int   errCnt   = 0;
    int   chkCnt   = 0;

    // Model state: index of the granted master (-1 = none) and the last winner.
    int mGnt = -1;
    int mPtr = N - 1;

    dbus_rr_arbiter_if #(.NUM_MASTERS(N), .ADDR_W(A), .DATA_W(D)) bus ();

    dbus_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(A), .DATA_W(D)) u_dut (
        .i_Clk  (w_SysClk),
        .i_nRst (r_nRst),
        .bus    (bus.slave)
    );

    always #5 w_SysClk = ~w_SysClk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First requester found walking forward from the last winner, wrapping around.
    function automatic int nextWin(input logic [N-1:0] req, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit lockHold();
`ifdef DBUS_ARB_LOCK_EN
        return (mGnt >= 0) && bus.i_M_Lock[mGnt] && bus.i_M_Req[mGnt];
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge w_SysClk or negedge r_nRst) begin
        if (!r_nRst) begin
            mGnt <= -1;
            mPtr <= N - 1;
        end else if (!bus.i_S_WaitRequest && !lockHold()) begin
            if (bus.i_M_Req == '0) begin
                mGnt <= -1;
            end else begin
                mGnt <= nextWin(bus.i_M_Req, mPtr);
                mPtr <= nextWin(bus.i_M_Req, mPtr);
            end
        end
    end

    function automatic logic [N-1:0] expGnt();
        if (mGnt < 0) return '0;
        return N'(1) << mGnt;
    endfunction

    function automatic logic [A-1:0] expAddr();
        if (mGnt < 0) return '0;
        return bus.i_M_Address[mGnt*A +: A];
    endfunction

    function automatic logic [BE-1:0] expBe();
        if (mGnt < 0) return '0;
        return bus.i_M_ByteEn[mGnt*BE +: BE];
    endfunction

    function automatic logic [D-1:0] expWd();
        if (mGnt < 0) return '0;
        return bus.i_M_WriteData[mGnt*D +: D];
    endfunction

    function automatic logic expRd();
        if (mGnt < 0) return 1'b0;
        return bus.i_M_Read[mGnt];
    endfunction

    function automatic logic expWr();
        if (mGnt < 0) return 1'b0;
        return bus.i_M_Write[mGnt];
    endfunction

    function automatic logic [N*D-1:0] expRdData();
        logic [N*D-1:0] r;
        r = '0;
        if (mGnt >= 0) r[mGnt*D +: D] = bus.i_S_ReadData;
        return r;
    endfunction

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge w_SysClk) begin
        if (cmpEn) begin
            check("gnt",     128'(bus.o_M_Gnt),         128'(expGnt()));
            check("lastIdx", 128'(bus.o_LastGntIdx),    128'(mPtr));
            check("sAddr",   128'(bus.o_S_Address),     128'(expAddr()));
            check("sByteEn", 128'(bus.o_S_ByteEn),      128'(expBe()));
            check("sWdata",  128'(bus.o_S_WriteData),   128'(expWd()));
            check("sRead",   128'(bus.o_S_Read),        128'(expRd()));
            check("sWrite",  128'(bus.o_S_Write),       128'(expWr()));
            check("mRdata",  128'(bus.o_M_ReadData),    128'(expRdData()));
            check("mWait",   128'(bus.o_M_WaitRequest), 128'(expGnt() & {N{bus.i_S_WaitRequest}}));
        end
    end

    task automatic step();
        @(posedge w_SysClk);
        #1;
    endtask

    logic [N-1:0] lockSeq [4];

    initial begin
        bus.i_M_Req         = '0;
        bus.i_M_Lock        = '0;
        bus.i_M_Read        = '0;
        bus.i_M_Write       = '0;
        bus.i_S_ReadData    = '0;
        bus.i_S_WaitRequest = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.i_M_Address[i*A +: A]   = A'(32'h100 + i);
            bus.i_M_ByteEn[i*BE +: BE]  = BE'(4'hF);
            bus.i_M_WriteData[i*D +: D] = D'(32'hA0 + i);
        end
        repeat (2) @(posedge w_SysClk);
        #1;
        r_nRst = 1'b1;
        cmpEn  = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_gnt",   128'(bus.o_M_Gnt),      128'(3'b000));
            check("idle_idx",   128'(bus.o_LastGntIdx), 128'(2'd2));
            check("idle_bus",   128'({bus.o_S_Address, bus.o_S_ByteEn, bus.o_S_Read, bus.o_S_Write, bus.o_S_WriteData}), 128'(0));
        end

        // All three requesting: strict rotation 0,1,2,0,1,2.
        bus.i_M_Req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_gnt",  128'(bus.o_M_Gnt),     128'(3'b001 << (i % 3)));
            check("rr_addr", 128'(bus.o_S_Address), 128'(32'h100 + (i % 3)));
        end

        // Master 1 reading, slave stalls for three cycles while master 0 waits.
        bus.i_M_Req  = 3'b010;
        bus.i_M_Read = 3'b010;
        step();
        check("st_gnt0", 128'(bus.o_M_Gnt), 128'(3'b010));
        bus.i_S_WaitRequest = 1'b1;
        bus.i_M_Req         = 3'b011;
        bus.i_M_Read        = 3'b011;
        bus.i_S_ReadData    = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_gnt",  128'(bus.o_M_Gnt),              128'(3'b010));
            check("st_wait", 128'(bus.o_M_WaitRequest),      128'(3'b010));
            check("st_rd1",  128'(bus.o_M_ReadData[D +: D]), 128'(32'hDEADBEEF));
            check("st_rd0",  128'(bus.o_M_ReadData[0 +: D]), 128'(0));
            check("st_rd2",  128'(bus.o_M_ReadData[2*D +: D]), 128'(0));
        end
        bus.i_S_WaitRequest = 1'b0;
        step();
        check("st_after", 128'(bus.o_M_Gnt), 128'(3'b001));
        bus.i_M_Read     = '0;
        bus.i_S_ReadData = '0;

        // Lone requester is granted back to back.
        bus.i_M_Req = 3'b100;
        for (int i = 0; i < 4; i++) begin
            step();
            check("lone_gnt", 128'(bus.o_M_Gnt),      128'(3'b100));
            check("lone_idx", 128'(bus.o_LastGntIdx), 128'(2'd2));
        end

        // Masters 0 and 2 requesting, master 0 locks for three cycles.
`ifdef DBUS_ARB_LOCK_EN
        lockSeq = '{3'b001, 3'b001, 3'b001, 3'b100};
`else
        lockSeq = '{3'b001, 3'b100, 3'b001, 3'b100};
`endif
        bus.i_M_Req  = 3'b101;
        bus.i_M_Lock = 3'b001;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.i_M_Lock = 3'b000;
            step();
            check("lock_gnt", 128'(bus.o_M_Gnt), 128'(lockSeq[i]));
        end
        bus.i_M_Req = 3'b000;
        step();

        // Asynchronous reset in the middle of a master-1 write.
        bus.i_M_Req   = 3'b010;
        bus.i_M_Write = 3'b010;
        step();
        check("rst_gnt_pre", 128'(bus.o_M_Gnt),   128'(3'b010));
        check("rst_wr_pre",  128'(bus.o_S_Write), 128'(1'b1));
        #2;
        r_nRst = 1'b0;
        #1;
        check("rst_wr",  128'(bus.o_S_Write), 128'(1'b0));
        check("rst_gnt", 128'(bus.o_M_Gnt),   128'(3'b000));
        bus.i_M_Req = 3'b110;
        step();
        r_nRst = 1'b1;
        step();
        check("rst_first", 128'(bus.o_M_Gnt), 128'(3'b010));
        bus.i_M_Write = '0;

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 400; i++) begin
            bus.i_M_Req         = N'($urandom);
            bus.i_M_Lock        = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            bus.i_M_Read        = N'($urandom);
            bus.i_M_Write       = N'($urandom);
            bus.i_M_Address     = {$urandom, $urandom, $urandom};
            bus.i_M_ByteEn      = (N*BE)'($urandom);
            bus.i_M_WriteData   = {$urandom, $urandom, $urandom};
            bus.i_S_ReadData    = $urandom;
            bus.i_S_WaitRequest = ($urandom_range(0, 3) == 0);
            step();
        end

        bus.i_M_Req         = '0;
        bus.i_M_Lock        = '0;
        bus.i_S_WaitRequest = 1'b0;
        step();
        step();
        cmpEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end
endmodule
